// File: rtl/ps2_flap_rx_pkg.sv
// Shared scan-code constants, receiver state encoding and parity helper
// for the PS/2 game-key receiver.
package ps2_flap_rx_pkg;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, clock filter, 11-bit frame FSM and mid-frame timeout.
// Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_rx
    import ps2_flap_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       frame_err,
    output logic       timeout
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_s;
    logic          dat_s;
    logic          filt;
    logic [FW-1:0] fcnt;
    logic          flip;
    logic          strobe;

    rx_state_t     state;
    rx_state_t     state_n;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] tcnt;
    logic          tc_hit;
    logic          accept;
    logic          ferr;

    assign clk_s  = clk_sync[1];
    assign dat_s  = dat_sync[1];
    assign flip   = (clk_s != filt) && (fcnt == FW'(FILTER_LEN - 1));
    assign strobe = flip && filt;
    // A strobe landing on the terminal count wins over the timeout.
    assign tc_hit = (state != ST_IDLE) && !strobe && (tcnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    logic perr;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_sync <= 2'b00;
            dat_sync <= 2'b00;
            filt     <= 1'b0;
            fcnt     <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            if (clk_s == filt) begin
                fcnt <= '0;
            end else if (flip) begin
                fcnt <= '0;
                filt <= clk_s;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        ferr    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        perr    = 1'b0;
`endif
        if (strobe) begin
            case (state)
                ST_IDLE:   if (!dat_s) state_n = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_n = ST_PARITY;
                ST_PARITY: state_n = ST_STOP;
                ST_STOP: begin
                    state_n = ST_IDLE;
                    if (!dat_s) begin
                        ferr = 1'b1;
                    end else begin
`ifdef PS2_PARITY_CHECK_EN
                        if (odd_parity_ok(shreg, par_bit)) accept = 1'b1;
                        else                               perr   = 1'b1;
`else
                        accept = 1'b1;
`endif
                    end
                end
                default:   state_n = ST_IDLE;
            endcase
        end else if (tc_hit) begin
            state_n = ST_IDLE;
            ferr    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            tcnt      <= '0;
        end else begin
            rx_valid  <= accept;
            frame_err <= ferr;
            timeout   <= tc_hit;
            if (accept) rx_byte <= shreg;
            if (strobe || tc_hit || state == ST_IDLE) tcnt <= '0;
            else                                      tcnt <= tcnt + 1'b1;
            if (strobe) begin
                case (state)
                    ST_IDLE: bit_cnt <= '0;
                    ST_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            par_bit       <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_parity_err <= perr;
            if (strobe && state == ST_PARITY) par_bit <= dat_s;
        end
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: rtl/ps2_flap_rx.sv
// PS/2 keyboard receiver with SPACE make/break decoder (space_held level, flap_pulse).
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module ps2_flap_rx
    import ps2_flap_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       frame_err,
    output logic       space_held,
    output logic       flap_pulse
);

    logic timeout;
    logic brk_pend;
    logic ext_pend;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk          (clk),
        .clr          (clr),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_parity_err(rx_parity_err),
        .frame_err    (frame_err),
        .timeout      (timeout)
    );

    // Extended SPACE codes (E0 29 / E0 F0 29) are not our key and are ignored.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            space_held <= 1'b0;
            flap_pulse <= 1'b0;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
        end else begin
            flap_pulse <= 1'b0;
            if (rx_valid) begin
                if (rx_byte == SC_BREAK) begin
                    brk_pend <= 1'b1;
                end else if (rx_byte == SC_EXT) begin
                    ext_pend <= 1'b1;
                end else begin
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                    if (rx_byte == SC_SPACE && !ext_pend) begin
                        if (brk_pend) begin
                            space_held <= 1'b0;
                        end else if (!space_held) begin
                            space_held <= 1'b1;
                            flap_pulse <= 1'b1;
                        end
                    end
                end
            end else if (timeout) begin
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_flap_rx.sv
// Scoreboard bench for ps2_flap_rx: stimulus pushes expected bytes/levels, a monitor pops on rx_valid.
module tb_ps2_flap_rx;

    localparam int HP  = 40;
    localparam int TMO = 500;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_parity_err, frame_err, space_held, flap_pulse;

    ps2_flap_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .clr          (clr),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_parity_err(rx_parity_err),
        .frame_err    (frame_err),
        .space_held   (space_held),
        .flap_pulse   (flap_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] b;
        logic       held;
        logic       flap;
    } exp_t;

    exp_t exp_q[$];
    int   exp_ferr = 0;
    int   exp_perr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: byte on rx_valid, decoder result one cycle later, error pulses against expected counts.
    initial begin : monitor
        exp_t cur;
        bit   post;
        post = 1'b0;
        forever begin
            @(negedge clk);
            if (post) begin
                chk("space_held", {31'd0, space_held}, {31'd0, cur.held});
                chk("flap_pulse", {31'd0, flap_pulse}, {31'd0, cur.flap});
                post = 1'b0;
            end else if (flap_pulse) begin
                chk("flap_unexpected", {31'd0, flap_pulse}, 32'd0);
            end
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("rx_byte", {24'd0, rx_byte}, {24'd0, cur.b});
                    post = 1'b1;
                end
            end
            if (frame_err) begin
                if (exp_ferr > 0) begin
                    exp_ferr--;
                    checks++;
                end else begin
                    chk("frame_err_unexpected", {31'd0, frame_err}, 32'd0);
                end
            end
            if (rx_parity_err) begin
                if (exp_perr > 0) begin
                    exp_perr--;
                    checks++;
                end else begin
                    chk("parity_err_unexpected", {31'd0, rx_parity_err}, 32'd0);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip, input logic stop);
        return {stop, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits, output int last_fall);
        last_fall = cyc;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(HP / 2);
            ps2_clk = 1'b0;
            last_fall = cyc;
            wait_cyc(HP);
            ps2_clk = 1'b1;
            wait_cyc(HP / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip, input logic stop);
        int lf;
        send_bits(mk_frame(b, flip, stop), 11, lf);
        wait_cyc(60);
    endtask

    task automatic push(input logic [7:0] b, input logic held, input logic flap);
        exp_t e;
        e.b = b; e.held = held; e.flap = flap;
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        @(negedge clk);
        chk({tag, "_rx_byte"},    {24'd0, rx_byte},      32'd0);
        chk({tag, "_rx_valid"},   {31'd0, rx_valid},     32'd0);
        chk({tag, "_frame_err"},  {31'd0, frame_err},    32'd0);
        chk({tag, "_parity_err"}, {31'd0, rx_parity_err}, 32'd0);
        chk({tag, "_space_held"}, {31'd0, space_held},   32'd0);
        chk({tag, "_flap"},       {31'd0, flap_pulse},   32'd0);
    endtask

    initial begin : stim
        int lf;
        int lat;
        bit got;

        clr = 1'b1;
        wait_cyc(5);
        chk_all_zero("reset");
        clr = 1'b0;
        wait_cyc(50);

        // 1: fresh SPACE make
        push(8'h29, 1'b1, 1'b1);
        send_byte(8'h29, 1'b0, 1'b1);

        // 2: typematic repeats then break
        for (int i = 0; i < 3; i++) begin
            push(8'h29, 1'b1, 1'b0);
            send_byte(8'h29, 1'b0, 1'b1);
        end
        push(8'hF0, 1'b1, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b1);
        push(8'h29, 1'b0, 1'b0);
        send_byte(8'h29, 1'b0, 1'b1);

        // 3: extended code ignored
        push(8'hE0, 1'b0, 1'b0);
        send_byte(8'hE0, 1'b0, 1'b1);
        push(8'h29, 1'b0, 1'b0);
        send_byte(8'h29, 1'b0, 1'b1);

        // 4: wrong parity bit
`ifdef PS2_PARITY_CHECK_EN
        exp_perr++;
        send_byte(8'h29, 1'b1, 1'b1);
        @(negedge clk);
        chk("parity_held", {31'd0, space_held}, 32'd0);
`else
        push(8'h29, 1'b1, 1'b1);
        send_byte(8'h29, 1'b1, 1'b1);
        push(8'hF0, 1'b1, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b1);
        push(8'h29, 1'b0, 1'b0);
        send_byte(8'h29, 1'b0, 1'b1);
`endif

        // 5: break pending, then truncated frame times out and clears it
        push(8'hF0, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b1);
        exp_ferr++;
        send_bits(mk_frame(8'h29, 1'b0, 1'b1), 5, lf);
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 700 && !got; i++) begin
            @(negedge clk);
            if (frame_err) begin
                got = 1'b1;
                lat = cyc - lf;
            end
        end
        chk("timeout_seen", {31'd0, got}, 32'd1);
        chk("timeout_latency_window", {31'd0, (lat >= TMO && lat <= TMO + 20)}, 32'd1);
        wait_cyc(100);
        push(8'h29, 1'b1, 1'b1);
        send_byte(8'h29, 1'b0, 1'b1);
        // bad stop bit on a break code: dropped, so the next SPACE is a repeat
        exp_ferr++;
        send_byte(8'hF0, 1'b0, 1'b0);
        push(8'h29, 1'b1, 1'b0);
        send_byte(8'h29, 1'b0, 1'b1);

        // 6: short glitch on ps2_clk in IDLE
        ps2_data = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(5);
        ps2_data = 1'b1;
        wait_cyc(TMO + 100);
        @(negedge clk);
        chk("glitch_held", {31'd0, space_held}, 32'd1);

        // reset mid-frame
        send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 4, lf);
        clr = 1'b1;
        wait_cyc(3);
        chk_all_zero("midreset");
        clr = 1'b0;
        wait_cyc(50);
        push(8'h29, 1'b1, 1'b1);
        send_byte(8'h29, 1'b0, 1'b1);

        wait_cyc(100);
        chk("pending_bytes", exp_q.size(), 32'd0);
        chk("pending_frame_err", exp_ferr, 32'd0);
        chk("pending_parity_err", exp_perr, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
